control_unit: RTL and testbench

Hardwired Mini SRC control sequencer that drives the datapath's control strobes. It steps a T-state machine through fetch (T0–T2) and a per-opcode execute sequence (T3–T7), decoding the IR value fed back from the datapath and sampling the branch condition (BranchOut). It sits beside the datapath in the CPU top level and is the only source of every register enable, bus-out select, ALU op and memory strobe.

---
 rtl/cpu_pkg.sv | 141 ++++++++++++++
 rtl/control_unit_step_decoder.sv | 181 ++++++++++++++++++
 rtl/control_unit.sv | 153 +++++++++++++++
 tb/tb_control_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared Mini SRC definitions: opcodes, sequencer states,
//               ALU operation codes and the 32-bit control-word layout.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Opcodes, IR[31:27]
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Sequencer states; T0..T7 are consecutive so "next step" is +1
    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        T0      = 4'd1,
        T1      = 4'd2,
        T2      = 4'd3,
        T3      = 4'd4,
        T4      = 4'd5,
        T5      = 4'd6,
        T6      = 4'd7,
        T7      = 4'd8,
        S_HALT  = 4'd9
    } state_t;

    // ALU operations are mutually exclusive, so they are carried encoded
    typedef enum logic [4:0] {
        ALU_NONE  = 5'd0,
        ALU_ADD   = 5'd1,
        ALU_SUB   = 5'd2,
        ALU_AND   = 5'd3,
        ALU_OR    = 5'd4,
        ALU_ROR   = 5'd5,
        ALU_ROL   = 5'd6,
        ALU_SHR   = 5'd7,
        ALU_SHRA  = 5'd8,
        ALU_SHL   = 5'd9,
        ALU_MUL   = 5'd10,
        ALU_DIV   = 5'd11,
        ALU_NEG   = 5'd12,
        ALU_NOT   = 5'd13,
        ALU_INCPC = 5'd14
    } alu_t;

    // 10 bus selects + 12 enables + 3 field selects + 2 strobes + 5 ALU = 32
    typedef struct packed {
        logic pc_out;
        logic zlow_out;
        logic zhigh_out;
        logic mdr_out;
        logic lo_out;
        logic hi_out;
        logic c_out;
        logic ba_out;
        logic rin_out;
        logic r_out;
        logic pc_in;
        logic ir_in;
        logic mar_in;
        logic mdr_in;
        logic y_in;
        logic z_in;
        logic lo_in;
        logic hi_in;
        logic r_in;
        logic ra_in;
        logic con_in;
        logic outport_in;
        logic gra;
        logic grb;
        logic grc;
        logic read;
        logic write;
        alu_t alu;
    } ctrl_word_t;

    // ALU operation used in the arithmetic step of an opcode
    function automatic alu_t alu_of(input logic [4:0] op);
        case (op)
            OP_ADD, OP_ADDI, OP_LD, OP_LDI, OP_ST, OP_BR: alu_of = ALU_ADD;
            OP_SUB:            alu_of = ALU_SUB;
            OP_AND, OP_ANDI:   alu_of = ALU_AND;
            OP_OR,  OP_ORI:    alu_of = ALU_OR;
            OP_ROR:            alu_of = ALU_ROR;
            OP_ROL:            alu_of = ALU_ROL;
            OP_SHR:            alu_of = ALU_SHR;
            OP_SHRA:           alu_of = ALU_SHRA;
            OP_SHL:            alu_of = ALU_SHL;
            OP_MUL:            alu_of = ALU_MUL;
            OP_DIV:            alu_of = ALU_DIV;
            OP_NEG:            alu_of = ALU_NEG;
            OP_NOT:            alu_of = ALU_NOT;
            default:           alu_of = ALU_NONE;
        endcase
    endfunction

    // Index of the final T-step of an opcode (2 means fetch only)
    function automatic logic [2:0] last_step(input logic [4:0] op);
        case (op)
            OP_LD:                                  last_step = 3'd7;
            OP_ST, OP_DIV, OP_MUL, OP_BR:           last_step = 3'd6;
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
            OP_ADDI, OP_ANDI, OP_ORI:               last_step = 3'd5;
            OP_NEG, OP_NOT, OP_JAL:                 last_step = 3'd4;
            OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO,
            OP_HALT:                                last_step = 3'd3;
            default:                                last_step = 3'd2;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_unit_step_decoder.sv
`default_nettype none
// ============================================================================
// Module      : step_decoder
// Description : Combinational decode of (state, latched opcode, BranchOut)
//               into the control word for the current T-step.
// Revision    : 1.0 - initial release
// ============================================================================
module step_decoder
    import cpu_pkg::*;
(
    input  state_t     state_i,
    input  logic [4:0] opcode_i,
    input  logic       branch_i,
    output ctrl_word_t cw_o
);

    // Strobes for the current step; everything not named stays low
    always_comb begin
        cw_o = '0;
        case (state_i)
            S_RESET, S_HALT: ;
            T0: begin
                cw_o.pc_out = 1'b1;
                cw_o.mar_in = 1'b1;
                cw_o.alu    = ALU_INCPC;
                cw_o.z_in   = 1'b1;
            end
            T1: begin
                cw_o.zlow_out = 1'b1;
                cw_o.pc_in    = 1'b1;
                cw_o.read     = 1'b1;
                cw_o.mdr_in   = 1'b1;
            end
            T2: begin
                cw_o.mdr_out = 1'b1;
                cw_o.ir_in   = 1'b1;
            end
            default: begin
                case (opcode_i)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR,
                    OP_SHRA, OP_SHL, OP_ADDI, OP_ANDI, OP_ORI: begin
                        case (state_i)
                            T3: begin
                                cw_o.grb = 1'b1; cw_o.r_out = 1'b1; cw_o.y_in = 1'b1;
                            end
                            T4: begin
                                // Immediate forms take operand C from the IR field
                                if (opcode_i == OP_ADDI || opcode_i == OP_ANDI ||
                                    opcode_i == OP_ORI) begin
                                    cw_o.c_out = 1'b1;
                                end else begin
                                    cw_o.grc = 1'b1; cw_o.r_out = 1'b1;
                                end
                                cw_o.alu  = alu_of(opcode_i);
                                cw_o.z_in = 1'b1;
                            end
                            T5: begin
                                cw_o.zlow_out = 1'b1; cw_o.gra = 1'b1; cw_o.r_in = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_DIV, OP_MUL: begin
                        case (state_i)
                            T3: begin
                                cw_o.gra = 1'b1; cw_o.r_out = 1'b1; cw_o.y_in = 1'b1;
                            end
                            T4: begin
                                cw_o.grb = 1'b1; cw_o.r_out = 1'b1;
                                cw_o.alu = alu_of(opcode_i); cw_o.z_in = 1'b1;
                            end
                            T5: begin
                                cw_o.zlow_out = 1'b1; cw_o.lo_in = 1'b1;
                            end
                            T6: begin
                                cw_o.zhigh_out = 1'b1; cw_o.hi_in = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_NEG, OP_NOT: begin
                        case (state_i)
                            T3: begin
                                cw_o.grb = 1'b1; cw_o.r_out = 1'b1;
                                cw_o.alu = alu_of(opcode_i); cw_o.z_in = 1'b1;
                            end
                            T4: begin
                                cw_o.zlow_out = 1'b1; cw_o.gra = 1'b1; cw_o.r_in = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_LD, OP_LDI, OP_ST: begin
                        case (state_i)
                            T3: begin
                                cw_o.grb = 1'b1; cw_o.ba_out = 1'b1; cw_o.y_in = 1'b1;
                            end
                            T4: begin
                                cw_o.c_out = 1'b1; cw_o.alu = ALU_ADD; cw_o.z_in = 1'b1;
                            end
                            T5: begin
                                cw_o.zlow_out = 1'b1;
                                // ldi writes the effective address itself
                                if (opcode_i == OP_LDI) begin
                                    cw_o.gra = 1'b1; cw_o.r_in = 1'b1;
                                end else begin
                                    cw_o.mar_in = 1'b1;
                                end
                            end
                            T6: begin
                                if (opcode_i == OP_ST) begin
                                    cw_o.gra = 1'b1; cw_o.r_out = 1'b1; cw_o.write = 1'b1;
                                end else begin
                                    cw_o.read = 1'b1; cw_o.mdr_in = 1'b1;
                                end
                            end
                            T7: begin
                                cw_o.mdr_out = 1'b1; cw_o.gra = 1'b1; cw_o.r_in = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_BR: begin
                        case (state_i)
                            T3: begin
                                cw_o.gra = 1'b1; cw_o.r_out = 1'b1; cw_o.con_in = 1'b1;
                            end
                            T4: begin
                                cw_o.pc_out = 1'b1; cw_o.y_in = 1'b1;
                            end
                            T5: begin
                                cw_o.c_out = 1'b1; cw_o.alu = ALU_ADD; cw_o.z_in = 1'b1;
                            end
                            T6: begin
                                // Target is loaded only when the condition holds
                                cw_o.zlow_out = branch_i;
                                cw_o.pc_in    = branch_i;
                            end
                            default: ;
                        endcase
                    end
                    OP_JR: begin
                        if (state_i == T3) begin
                            cw_o.gra = 1'b1; cw_o.r_out = 1'b1; cw_o.pc_in = 1'b1;
                        end
                    end
                    OP_JAL: begin
                        if (state_i == T3) begin
                            cw_o.pc_out = 1'b1; cw_o.ra_in = 1'b1;
                        end else if (state_i == T4) begin
                            cw_o.gra = 1'b1; cw_o.r_out = 1'b1; cw_o.pc_in = 1'b1;
                        end
                    end
                    OP_IN: begin
                        if (state_i == T3) begin
                            cw_o.rin_out = 1'b1; cw_o.gra = 1'b1; cw_o.r_in = 1'b1;
                        end
                    end
                    OP_OUT: begin
                        if (state_i == T3) begin
                            cw_o.gra = 1'b1; cw_o.r_out = 1'b1; cw_o.outport_in = 1'b1;
                        end
                    end
                    OP_MFHI: begin
                        if (state_i == T3) begin
                            cw_o.hi_out = 1'b1; cw_o.gra = 1'b1; cw_o.r_in = 1'b1;
                        end
                    end
                    OP_MFLO: begin
                        if (state_i == T3) begin
                            cw_o.lo_out = 1'b1; cw_o.gra = 1'b1; cw_o.r_in = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module      : control_unit
// Description : Hardwired Mini SRC control sequencer. Steps fetch T0-T2 and
//               the per-opcode execute steps, latches the opcode at the end
//               of T2 and drives every datapath control strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module control_unit
    import cpu_pkg::*;
(
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        BranchOut,
    input  logic        Stop,
    output logic        PCout,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        MDRout,
    output logic        LOout,
    output logic        HIout,
    output logic        Cout,
    output logic        BAout,
    output logic        RINout,
    output logic        Rout,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        Zin,
    output logic        LOin,
    output logic        HIin,
    output logic        Rin,
    output logic        RAin,
    output logic        CONin,
    output logic        OutPortIn,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Read,
    output logic        Write,
    output logic        IncPC,
    output logic        ADD,
    output logic        SUB,
    output logic        AND,
    output logic        OR,
    output logic        ROR,
    output logic        ROL,
    output logic        SHR,
    output logic        SHRA,
    output logic        SHL,
    output logic        MUL,
    output logic        DIV,
    output logic        NEG,
    output logic        NOT,
    output logic        Run
);

    state_t     state_q, state_d;
    logic [4:0] opcode_q;
    logic [4:0] w_op;
    ctrl_word_t w_cw;

    // In T2 the opcode is not latched yet, so the sequence length comes from IR
    assign w_op = (state_q == T2) ? IR[31:27] : opcode_q;

    // Next T-step: advance, or finish the instruction and honour Stop
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = T0;
            S_HALT:  state_d = S_HALT;
            default: begin
                if (state_q == T3 && w_op == OP_HALT) begin
                    state_d = S_HALT;
                end else if ((4'(state_q) - 4'(T0)) == {1'b0, last_step(w_op)}) begin
                    state_d = Stop ? S_HALT : T0;
                end else begin
                    state_d = state_t'(4'(state_q) + 4'd1);
                end
            end
        endcase
    end

    // State register and opcode latch, cleared asynchronously
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q  <= S_RESET;
            opcode_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == T2) begin
                opcode_q <= IR[31:27];
            end
        end
    end

    step_decoder u_step_decoder (
        .state_i  (state_q),
        .opcode_i (opcode_q),
        .branch_i (BranchOut),
        .cw_o     (w_cw)
    );

    assign PCout     = w_cw.pc_out;
    assign Zlowout   = w_cw.zlow_out;
    assign Zhighout  = w_cw.zhigh_out;
    assign MDRout    = w_cw.mdr_out;
    assign LOout     = w_cw.lo_out;
    assign HIout     = w_cw.hi_out;
    assign Cout      = w_cw.c_out;
    assign BAout     = w_cw.ba_out;
    assign RINout    = w_cw.rin_out;
    assign Rout      = w_cw.r_out;
    assign PCin      = w_cw.pc_in;
    assign IRin      = w_cw.ir_in;
    assign MARin     = w_cw.mar_in;
    assign MDRin     = w_cw.mdr_in;
    assign Yin       = w_cw.y_in;
    assign Zin       = w_cw.z_in;
    assign LOin      = w_cw.lo_in;
    assign HIin      = w_cw.hi_in;
    assign Rin       = w_cw.r_in;
    assign RAin      = w_cw.ra_in;
    assign CONin     = w_cw.con_in;
    assign OutPortIn = w_cw.outport_in;
    assign Gra       = w_cw.gra;
    assign Grb       = w_cw.grb;
    assign Grc       = w_cw.grc;
    assign Read      = w_cw.read;
    assign Write     = w_cw.write;

    assign IncPC = (w_cw.alu == ALU_INCPC);
    assign ADD   = (w_cw.alu == ALU_ADD);
    assign SUB   = (w_cw.alu == ALU_SUB);
    assign AND   = (w_cw.alu == ALU_AND);
    assign OR    = (w_cw.alu == ALU_OR);
    assign ROR   = (w_cw.alu == ALU_ROR);
    assign ROL   = (w_cw.alu == ALU_ROL);
    assign SHR   = (w_cw.alu == ALU_SHR);
    assign SHRA  = (w_cw.alu == ALU_SHRA);
    assign SHL   = (w_cw.alu == ALU_SHL);
    assign MUL   = (w_cw.alu == ALU_MUL);
    assign DIV   = (w_cw.alu == ALU_DIV);
    assign NEG   = (w_cw.alu == ALU_NEG);
    assign NOT   = (w_cw.alu == ALU_NOT);

    assign Run = (state_q != S_RESET) && (state_q != S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_unit
// Description : Scoreboard bench for control_unit. Each driven cycle pushes
//               the expected strobe vector derived from per-opcode step
//               tables; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;

    typedef logic [41:0] vec_t;

    localparam vec_t M_RUN      = vec_t'(1) << 41;
    localparam vec_t M_PCOUT    = vec_t'(1) << 40;
    localparam vec_t M_ZLOW     = vec_t'(1) << 39;
    localparam vec_t M_ZHIGH    = vec_t'(1) << 38;
    localparam vec_t M_MDROUT   = vec_t'(1) << 37;
    localparam vec_t M_LOOUT    = vec_t'(1) << 36;
    localparam vec_t M_HIOUT    = vec_t'(1) << 35;
    localparam vec_t M_COUT     = vec_t'(1) << 34;
    localparam vec_t M_BAOUT    = vec_t'(1) << 33;
    localparam vec_t M_RINOUT   = vec_t'(1) << 32;
    localparam vec_t M_ROUT     = vec_t'(1) << 31;
    localparam vec_t M_PCIN     = vec_t'(1) << 30;
    localparam vec_t M_IRIN     = vec_t'(1) << 29;
    localparam vec_t M_MARIN    = vec_t'(1) << 28;
    localparam vec_t M_MDRIN    = vec_t'(1) << 27;
    localparam vec_t M_YIN      = vec_t'(1) << 26;
    localparam vec_t M_ZIN      = vec_t'(1) << 25;
    localparam vec_t M_LOIN     = vec_t'(1) << 24;
    localparam vec_t M_HIIN     = vec_t'(1) << 23;
    localparam vec_t M_RIN      = vec_t'(1) << 22;
    localparam vec_t M_RAIN     = vec_t'(1) << 21;
    localparam vec_t M_CONIN    = vec_t'(1) << 20;
    localparam vec_t M_OUTPORT  = vec_t'(1) << 19;
    localparam vec_t M_GRA      = vec_t'(1) << 18;
    localparam vec_t M_GRB      = vec_t'(1) << 17;
    localparam vec_t M_GRC      = vec_t'(1) << 16;
    localparam vec_t M_READ     = vec_t'(1) << 15;
    localparam vec_t M_WRITE    = vec_t'(1) << 14;
    localparam vec_t M_INCPC    = vec_t'(1) << 13;
    localparam vec_t M_ADD      = vec_t'(1) << 12;
    localparam vec_t M_SUB      = vec_t'(1) << 11;
    localparam vec_t M_AND      = vec_t'(1) << 10;
    localparam vec_t M_OR       = vec_t'(1) << 9;
    localparam vec_t M_ROR      = vec_t'(1) << 8;
    localparam vec_t M_ROL      = vec_t'(1) << 7;
    localparam vec_t M_SHR      = vec_t'(1) << 6;
    localparam vec_t M_SHRA     = vec_t'(1) << 5;
    localparam vec_t M_SHL      = vec_t'(1) << 4;
    localparam vec_t M_MUL      = vec_t'(1) << 3;
    localparam vec_t M_DIV      = vec_t'(1) << 2;
    localparam vec_t M_NEG      = vec_t'(1) << 1;
    localparam vec_t M_NOT      = vec_t'(1) << 0;

    logic        Clock = 1'b0;
    logic        Clear;
    logic [31:0] IR;
    logic        BranchOut;
    logic        Stop;
    logic PCout, Zlowout, Zhighout, MDRout, LOout, HIout, Cout, BAout, RINout, Rout;
    logic PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin, Rin, RAin, CONin, OutPortIn;
    logic Gra, Grb, Grc, Read, Write;
    logic IncPC, ADD, SUB, AND, OR, ROR, ROL, SHR, SHRA, SHL, MUL, DIV, NEG, NOT;
    logic Run;

    vec_t obs;
    vec_t exp_q[$];
    vec_t prog[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    always #5 Clock = ~Clock;

    control_unit dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .BranchOut(BranchOut), .Stop(Stop),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .LOout(LOout), .HIout(HIout), .Cout(Cout), .BAout(BAout), .RINout(RINout),
        .Rout(Rout), .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
        .Yin(Yin), .Zin(Zin), .LOin(LOin), .HIin(HIin), .Rin(Rin), .RAin(RAin),
        .CONin(CONin), .OutPortIn(OutPortIn), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Read(Read), .Write(Write), .IncPC(IncPC), .ADD(ADD), .SUB(SUB), .AND(AND),
        .OR(OR), .ROR(ROR), .ROL(ROL), .SHR(SHR), .SHRA(SHRA), .SHL(SHL),
        .MUL(MUL), .DIV(DIV), .NEG(NEG), .NOT(NOT), .Run(Run)
    );

    assign obs = {Run, PCout, Zlowout, Zhighout, MDRout, LOout, HIout, Cout, BAout,
                  RINout, Rout, PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin, Rin,
                  RAin, CONin, OutPortIn, Gra, Grb, Grc, Read, Write, IncPC, ADD, SUB,
                  AND, OR, ROR, ROL, SHR, SHRA, SHL, MUL, DIV, NEG, NOT};

    // Monitor: one expected vector per driven cycle, compared mid-cycle
    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            vec_t e;
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL strobes cycle %0d: got %h expected %h", cycle, obs, e);
            end
            cycle++;
        end
    end

    function automatic vec_t alu_mask(input logic [4:0] op);
        case (op)
            5'd3, 5'd12: return M_ADD;
            5'd4:        return M_SUB;
            5'd5, 5'd13: return M_AND;
            5'd6, 5'd14: return M_OR;
            5'd7:        return M_ROR;
            5'd8:        return M_ROL;
            5'd9:        return M_SHR;
            5'd10:       return M_SHRA;
            5'd11:       return M_SHL;
            5'd15:       return M_DIV;
            5'd16:       return M_MUL;
            5'd17:       return M_NEG;
            5'd18:       return M_NOT;
            default:     return '0;
        endcase
    endfunction

    // Whole-instruction step list; the br T6 entry is filled in per cycle
    task automatic build(input logic [4:0] op);
        prog = {M_PCOUT | M_MARIN | M_INCPC | M_ZIN,
                M_ZLOW | M_PCIN | M_READ | M_MDRIN,
                M_MDROUT | M_IRIN};
        if (op >= 5'd3 && op <= 5'd11) begin
            prog.push_back(M_GRB | M_ROUT | M_YIN);
            prog.push_back(M_GRC | M_ROUT | alu_mask(op) | M_ZIN);
            prog.push_back(M_ZLOW | M_GRA | M_RIN);
        end else if (op >= 5'd12 && op <= 5'd14) begin
            prog.push_back(M_GRB | M_ROUT | M_YIN);
            prog.push_back(M_COUT | alu_mask(op) | M_ZIN);
            prog.push_back(M_ZLOW | M_GRA | M_RIN);
        end else if (op == 5'd15 || op == 5'd16) begin
            prog.push_back(M_GRA | M_ROUT | M_YIN);
            prog.push_back(M_GRB | M_ROUT | alu_mask(op) | M_ZIN);
            prog.push_back(M_ZLOW | M_LOIN);
            prog.push_back(M_ZHIGH | M_HIIN);
        end else if (op == 5'd17 || op == 5'd18) begin
            prog.push_back(M_GRB | M_ROUT | alu_mask(op) | M_ZIN);
            prog.push_back(M_ZLOW | M_GRA | M_RIN);
        end else if (op <= 5'd2) begin
            prog.push_back(M_GRB | M_BAOUT | M_YIN);
            prog.push_back(M_COUT | M_ADD | M_ZIN);
            if (op == 5'd1) begin
                prog.push_back(M_ZLOW | M_GRA | M_RIN);
            end else begin
                prog.push_back(M_ZLOW | M_MARIN);
                if (op == 5'd2) begin
                    prog.push_back(M_GRA | M_ROUT | M_WRITE);
                end else begin
                    prog.push_back(M_READ | M_MDRIN);
                    prog.push_back(M_MDROUT | M_GRA | M_RIN);
                end
            end
        end else begin
            case (op)
                5'd19: begin
                    prog.push_back(M_GRA | M_ROUT | M_CONIN);
                    prog.push_back(M_PCOUT | M_YIN);
                    prog.push_back(M_COUT | M_ADD | M_ZIN);
                    prog.push_back('0);
                end
                5'd20: prog.push_back(M_GRA | M_ROUT | M_PCIN);
                5'd21: begin
                    prog.push_back(M_PCOUT | M_RAIN);
                    prog.push_back(M_GRA | M_ROUT | M_PCIN);
                end
                5'd22: prog.push_back(M_RINOUT | M_GRA | M_RIN);
                5'd23: prog.push_back(M_GRA | M_ROUT | M_OUTPORT);
                5'd24: prog.push_back(M_HIOUT | M_GRA | M_RIN);
                5'd25: prog.push_back(M_LOOUT | M_GRA | M_RIN);
                5'd27: prog.push_back('0);
                default: ;
            endcase
        end
    endtask

    // Execute one instruction; abort_at>=0 pulls Clear low in that step
    task automatic run_instr(input logic [31:0] ir_w, input bit stop_end,
                             input int abort_at, input int br_force);
        logic [4:0] op;
        vec_t e;
        op = ir_w[31:27];
        build(op);
        for (int i = 0; i < prog.size(); i++) begin
            @(posedge Clock); #1;
            IR        = (i == 2) ? ir_w : $urandom;
            BranchOut = (br_force < 0) ? 1'($urandom) : br_force[0];
            Stop      = (i == prog.size() - 1) ? stop_end : 1'($urandom);
            if (i == abort_at) begin
                Clear = 1'b0;
                exp_q.push_back('0);
                return;
            end
            e = prog[i] | M_RUN;
            if (op == 5'd19 && i == 6 && BranchOut) e |= M_ZLOW | M_PCIN;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock); #1;
            Clear = 1'b0; IR = $urandom; Stop = 1'($urandom); BranchOut = 1'($urandom);
            exp_q.push_back('0);
        end
        @(posedge Clock); #1;
        Clear = 1'b1; Stop = 1'b0;
        exp_q.push_back('0);
    endtask

    task automatic idle_halted(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock); #1;
            IR = $urandom; Stop = 1'($urandom); BranchOut = 1'($urandom);
            exp_q.push_back('0);
        end
    endtask

    function automatic logic [31:0] rand_ir();
        logic [4:0] op;
        op = 5'($urandom_range(0, 31));
        if (op == 5'd27) op = 5'd26;
        return {op, 27'($urandom)};
    endfunction

    initial begin
        Clear = 1'b0; IR = '0; Stop = 1'b0; BranchOut = 1'b0;
        do_reset(3);
        run_instr(32'h18910000, 1'b0, -1, -1);
        run_instr(32'h00800055, 1'b0, -1, -1);
        run_instr(32'h99800023, 1'b0, -1, 0);
        run_instr(32'h99800023, 1'b0, -1, 1);
        run_instr({5'd16, 27'h0123456}, 1'b0, -1, -1);
        for (int k = 0; k < 60; k++) run_instr(rand_ir(), 1'b0, -1, -1);
        run_instr(rand_ir(), 1'b1, -1, -1);
        idle_halted(4);
        do_reset(2);
        run_instr({5'd15, 27'h0abcdef}, 1'b0, 4, -1);
        do_reset(1);
        run_instr({5'd3, 27'h1}, 1'b0, -1, -1);
        run_instr({5'd21, 27'h2}, 1'b0, -1, -1);
        run_instr({5'd26, 27'h3}, 1'b0, -1, -1);
        run_instr({5'd16, 27'h4}, 1'b0, -1, -1);
        run_instr({5'd27, 27'h5}, 1'b0, -1, -1);
        idle_halted(10);
        repeat (3) @(negedge Clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
